serial_argmax_feeder: RTL

SERIAL_ARGMAX_FEEDER -- requirements
Module: serial_argmax_feeder

---
 rtl/serial_argmax_feeder_pkg.sv | 22 ++
 rtl/serial_argmax_feeder_chunk_argmax.sv | 52 +++++
 rtl/serial_argmax_feeder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/serial_argmax_feeder_pkg.sv
// Shared constants and state encoding for the serial argmax feeder and the
// chunk-level argmax datapath it drives.
package serial_argmax_feeder_pkg;

    localparam int DEF_WIDTH           = 8;
    localparam int DEF_LANES           = 16;
    localparam int DEF_LANE_IDX_WIDTH  = 4;
    localparam int DEF_NUM_CHUNKS      = 8;
    localparam int DEF_CHUNK_IDX_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_HOLD   = 2'd2
    } feeder_state_e;

    // Smallest power of two >= n; sizes the comparison tree leaves.
    function automatic int pow2_ceil(input int n);
        return 32'sd1 << $clog2(n);
    endfunction

endpackage

// File: rtl/serial_argmax_feeder_chunk_argmax.sv
// Combinational signed max/argmax over one chunk of LANES elements, built as a
// balanced tree whose left subtrees always hold the lower lane indices.
module chunk_argmax
    import serial_argmax_feeder_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int LANES          = DEF_LANES,
    parameter int LANE_IDX_WIDTH = DEF_LANE_IDX_WIDTH
)(
    input  logic [LANES*WIDTH-1:0]    i_chunk,
    output logic [WIDTH-1:0]          o_max,
    output logic [LANE_IDX_WIDTH-1:0] o_argmax
);

    localparam int PADDED = pow2_ceil(LANES);
    localparam int NODES  = 2 * PADDED - 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0]   w_val [NODES];
    logic [LANE_IDX_WIDTH-1:0] w_idx [NODES];

    // Heap-ordered tree: leaves at PADDED-1.., node n has children 2n+1 / 2n+2.
    // The right child wins only on strictly greater, so ties keep the lower lane;
    // padding leaves hold the minimum and can never displace a real lane.
    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            w_val[n] = '0;
            w_idx[n] = '0;
        end
        for (int i = 0; i < PADDED; i++) begin
            if (i < LANES) begin
                w_val[PADDED-1+i] = i_chunk[i*WIDTH +: WIDTH];
                w_idx[PADDED-1+i] = LANE_IDX_WIDTH'(i);
            end else begin
                w_val[PADDED-1+i] = MIN_VAL;
                w_idx[PADDED-1+i] = '0;
            end
        end
        for (int n = PADDED - 2; n >= 0; n--) begin
            if (w_val[2*n+2] > w_val[2*n+1]) begin
                w_val[n] = w_val[2*n+2];
                w_idx[n] = w_idx[2*n+2];
            end else begin
                w_val[n] = w_val[2*n+1];
                w_idx[n] = w_idx[2*n+1];
            end
        end
        o_max    = w_val[0];
        o_argmax = w_idx[0];
    end

endmodule

// File: rtl/serial_argmax_feeder.sv
// Buffers one vector and presents it chunk by chunk as (max, argmax, chunk)
// results to a downstream serial argmax stage under valid/ready handshaking.
module serial_argmax_feeder
    import serial_argmax_feeder_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int LANES           = DEF_LANES,
    parameter int LANE_IDX_WIDTH  = DEF_LANE_IDX_WIDTH,
    parameter int NUM_CHUNKS      = DEF_NUM_CHUNKS,
    parameter int CHUNK_IDX_WIDTH = DEF_CHUNK_IDX_WIDTH
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_CHUNKS*LANES*WIDTH-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_max,
    output logic [LANE_IDX_WIDTH-1:0]        out_argmax,
    output logic [CHUNK_IDX_WIDTH-1:0]       out_chunk,
    output logic                             out_last
);

    localparam int CHUNK_BITS = LANES * WIDTH;
    localparam int VEC_BITS   = NUM_CHUNKS * CHUNK_BITS;
    localparam logic [CHUNK_IDX_WIDTH-1:0] LAST_CHUNK = CHUNK_IDX_WIDTH'(NUM_CHUNKS - 1);
    localparam logic [WIDTH-1:0]           MIN_VAL    = {1'b1, {(WIDTH-1){1'b0}}};

    feeder_state_e r_state;
    feeder_state_e w_next_state;

    logic [VEC_BITS-1:0]        r_buf;
    logic [CHUNK_IDX_WIDTH-1:0] r_chunk_cnt;
    logic [CHUNK_BITS-1:0]      w_chunk_data;
    logic [WIDTH-1:0]           w_chunk_max;
    logic [LANE_IDX_WIDTH-1:0]  w_chunk_arg;

    logic w_capture;
    logic w_load;
    logic w_advance;
    logic w_finish;

    logic                       r_out_valid;
    logic [WIDTH-1:0]           r_out_max;
    logic [LANE_IDX_WIDTH-1:0]  r_out_argmax;
    logic [CHUNK_IDX_WIDTH-1:0] r_out_chunk;
    logic                       r_out_last;

    assign w_chunk_data = r_buf[int'(r_chunk_cnt)*CHUNK_BITS +: CHUNK_BITS];

    chunk_argmax #(
        .WIDTH          (WIDTH),
        .LANES          (LANES),
        .LANE_IDX_WIDTH (LANE_IDX_WIDTH)
    ) u_chunk_argmax (
        .i_chunk  (w_chunk_data),
        .o_max    (w_chunk_max),
        .o_argmax (w_chunk_arg)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; HOLD is the only state with out_valid set, so out_ready
    // is naturally ignored everywhere else.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_STREAM;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_STREAM: begin
                w_load       = 1'b1;
                w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (r_chunk_cnt == LAST_CHUNK) begin
                        w_finish     = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_advance    = 1'b1;
                        w_next_state = ST_STREAM;
                    end
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Vector buffer: written only on acceptance, deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf <= in_data;
        end
    end

    // Chunk counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chunk_cnt <= '0;
        end else if (w_capture) begin
            r_chunk_cnt <= '0;
        end else if (w_advance) begin
            r_chunk_cnt <= r_chunk_cnt + CHUNK_IDX_WIDTH'(1);
        end
    end

    // Result registers; out_last tracks out_chunk so the two never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_max    <= MIN_VAL;
            r_out_argmax <= '0;
            r_out_chunk  <= '0;
            r_out_last   <= 1'b0;
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out_max    <= w_chunk_max;
            r_out_argmax <= w_chunk_arg;
            r_out_chunk  <= r_chunk_cnt;
            r_out_last   <= (r_chunk_cnt == LAST_CHUNK);
        end else if (w_advance || w_finish) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign out_max    = r_out_max;
    assign out_argmax = r_out_argmax;
    assign out_chunk  = r_out_chunk;
    assign out_last   = r_out_last;

endmodule
